// File: rtl/alu_pkg.sv
// Shared definitions for the LEGv8-subset control path: ALU op codes,
// opcode fields, sequencer states and instruction classes.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'b000,
      ALU_SUB   = 3'b001,
      ALU_AND   = 3'b010,
      ALU_ORR   = 3'b011,
      ALU_PASSB = 3'b100
   } alu_op_e;

   localparam int unsigned OPC_R_W  = 11;  // instr[31:21]
   localparam int unsigned OPC_CB_W = 8;   // instr[31:24]
   localparam int unsigned OPC_B_W  = 6;   // instr[31:26]

   localparam logic [OPC_R_W-1:0]  OPC_ADD  = 11'b10001011000;
   localparam logic [OPC_R_W-1:0]  OPC_SUB  = 11'b11001011000;
   localparam logic [OPC_R_W-1:0]  OPC_AND  = 11'b10001010000;
   localparam logic [OPC_R_W-1:0]  OPC_ORR  = 11'b10101010000;
   localparam logic [OPC_R_W-1:0]  OPC_LDUR = 11'b11111000010;
   localparam logic [OPC_R_W-1:0]  OPC_STUR = 11'b11111000000;
   localparam logic [OPC_CB_W-1:0] OPC_CBZ  = 8'b10110100;
   localparam logic [OPC_B_W-1:0]  OPC_B    = 6'b000101;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB
   } state_e;

   typedef enum logic [2:0] {
      CLS_RTYPE,
      CLS_LDUR,
      CLS_STUR,
      CLS_CBZ,
      CLS_B,
      CLS_ILLEGAL
   } cls_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode classifier: top opcode bits -> instruction class and ALU op.
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic [10:0] i_opc,
   output logic [2:0]  o_cls,
   output logic [2:0]  o_alu_op
);

   cls_e    w_cls;
   alu_op_e w_op;

   always_comb begin
      w_cls = CLS_ILLEGAL;
      w_op  = ALU_ADD;
      if (i_opc == OPC_ADD) begin
         w_cls = CLS_RTYPE;
         w_op  = ALU_ADD;
      end else if (i_opc == OPC_SUB) begin
         w_cls = CLS_RTYPE;
         w_op  = ALU_SUB;
      end else if (i_opc == OPC_AND) begin
         w_cls = CLS_RTYPE;
         w_op  = ALU_AND;
      end else if (i_opc == OPC_ORR) begin
         w_cls = CLS_RTYPE;
         w_op  = ALU_ORR;
      end else if (i_opc == OPC_LDUR) begin
         w_cls = CLS_LDUR;
      end else if (i_opc == OPC_STUR) begin
         w_cls = CLS_STUR;
      end else if (i_opc[10:3] == OPC_CBZ) begin
         w_cls = CLS_CBZ;
         w_op  = ALU_PASSB;
      end else if (i_opc[10:5] == OPC_B) begin
         w_cls = CLS_B;
      end
   end

   assign o_cls    = w_cls;
   assign o_alu_op = w_op;

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle LEGv8-subset control sequencer: accepts one instruction per
// handshake and steps DECODE/EXEC/MEM/WB, driving ALU, memory and PC strobes.
module alu_ctrl_fsm
   import alu_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 1,
   parameter int unsigned INSTR_W     = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [INSTR_W-1:0] instr,
   input  logic               zero,
   output logic [2:0]         alu_op,
   output logic               alu_src,
   output logic               reg2_loc,
   output logic               reg_write,
   output logic               mem_to_reg,
   output logic               mem_read,
   output logic               mem_write,
   output logic               pc_write,
   output logic               pc_branch,
   output logic               illegal
);

   localparam logic [3:0] LP_CNT_INIT = 4'(MEM_LATENCY - 1);

   state_e             r_state, w_state_nxt;
   logic [INSTR_W-1:0] r_instr;
   logic [3:0]         r_cnt, w_cnt_nxt;
   logic [2:0]         w_cls_raw;
   logic [2:0]         w_alu_op;
   cls_e               w_cls;
   logic               w_is_ldur, w_is_stur;
   logic               w_unused_instr;

   alu_ctrl_decode u_decode (
      .i_opc    (r_instr[31:21]),
      .o_cls    (w_cls_raw),
      .o_alu_op (w_alu_op)
   );

   assign w_cls          = cls_e'(w_cls_raw);
   assign w_is_ldur      = (w_cls == CLS_LDUR);
   assign w_is_stur      = (w_cls == CLS_STUR);
   // Operand fields are consumed by the datapath, not by the sequencer.
   assign w_unused_instr = ^r_instr[20:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_instr <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (r_state == ST_IDLE && instr_valid)
            r_instr <= instr;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      instr_ready = 1'b0;
      alu_op      = ALU_ADD;
      alu_src     = 1'b0;
      reg2_loc    = 1'b0;
      reg_write   = 1'b0;
      mem_to_reg  = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      pc_write    = 1'b0;
      pc_branch   = 1'b0;
      illegal     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid)
               w_state_nxt = ST_DECODE;
         end
         ST_DECODE: begin
            case (w_cls)
               CLS_B: begin
                  pc_write    = 1'b1;
                  pc_branch   = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
               CLS_ILLEGAL: begin
                  illegal     = 1'b1;
                  pc_write    = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
               default: w_state_nxt = ST_EXEC;
            endcase
         end
         ST_EXEC: begin
            alu_op   = w_alu_op;
            alu_src  = w_is_ldur | w_is_stur;
            reg2_loc = w_is_stur | (w_cls == CLS_CBZ);
            case (w_cls)
               CLS_CBZ: begin
                  pc_write    = 1'b1;
                  pc_branch   = zero;
                  w_state_nxt = ST_IDLE;
               end
               CLS_LDUR, CLS_STUR: begin
                  w_cnt_nxt   = LP_CNT_INIT;
                  w_state_nxt = ST_MEM;
               end
               default: w_state_nxt = ST_WB;
            endcase
         end
         ST_MEM: begin
            // Address operands held so the memory sees a stable address.
            alu_op    = w_alu_op;
            alu_src   = 1'b1;
            reg2_loc  = w_is_stur;
            mem_read  = w_is_ldur;
            mem_write = w_is_stur;
            if (r_cnt == '0) begin
               if (w_is_ldur) begin
                  w_state_nxt = ST_WB;
               end else begin
                  pc_write    = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         ST_WB: begin
            alu_op      = w_alu_op;
            alu_src     = w_is_ldur;
            reg_write   = 1'b1;
            mem_to_reg  = w_is_ldur;
            pc_write    = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed bench for alu_ctrl_fsm: two instances (MEM_LATENCY 3 and 4) share stimulus.
module tb_alu_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic [31:0] instr;
   logic        zero;

   logic       rdy_a, src_a, r2l_a, rw_a, m2r_a, mr_a, mw_a, pcw_a, pcb_a, ill_a;
   logic [2:0] op_a;
   logic       rdy_b, src_b, r2l_b, rw_b, m2r_b, mr_b, mw_b, pcw_b, pcb_b, ill_b;
   logic [2:0] op_b;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;
   int unsigned n_excl = 0;
   int unsigned n_pcw = 0;
   logic        cnt_en = 1'b0;

   localparam logic [31:0] I_ADD  = 32'h8B030041;
   localparam logic [31:0] I_SUB  = 32'hCB030041;
   localparam logic [31:0] I_ORR  = 32'hAA030041;
   localparam logic [31:0] I_LDUR = 32'hF8408041;
   localparam logic [31:0] I_STUR = 32'hF8000041;
   localparam logic [31:0] I_CBZ  = 32'hB4000045;
   localparam logic [31:0] I_B    = 32'h14000010;
   localparam logic [31:0] I_BAD  = 32'h00000000;

   always #5 clk = ~clk;

   alu_ctrl_fsm #(.MEM_LATENCY(3), .INSTR_W(32)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(rdy_a),
      .instr(instr), .zero(zero), .alu_op(op_a), .alu_src(src_a), .reg2_loc(r2l_a),
      .reg_write(rw_a), .mem_to_reg(m2r_a), .mem_read(mr_a), .mem_write(mw_a),
      .pc_write(pcw_a), .pc_branch(pcb_a), .illegal(ill_a)
   );

   alu_ctrl_fsm #(.MEM_LATENCY(4), .INSTR_W(32)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(rdy_b),
      .instr(instr), .zero(zero), .alu_op(op_b), .alu_src(src_b), .reg2_loc(r2l_b),
      .reg_write(rw_b), .mem_to_reg(m2r_b), .mem_read(mr_b), .mem_write(mw_b),
      .pc_write(pcw_b), .pc_branch(pcb_b), .illegal(ill_b)
   );

   always @(negedge clk) begin
      if ((rw_a && mw_a) || (rw_b && mw_b))
         n_excl++;
      if (cnt_en && pcw_a)
         n_pcw++;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Single-cycle handshake; the bus is scrambled afterwards to show it is ignored.
   task automatic issue(input logic [31:0] w);
      instr       = w;
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      instr       = 32'hFFFF_FFFF;
   endtask

   initial begin
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = '0;
      zero        = 1'b0;
      step();
      step();
      check("rst_pcw", 32'(pcw_a), 0);
      check("rst_rw",  32'(rw_a),  0);
      check("rst_mem", 32'({mr_a, mw_a, mr_b, mw_b}), 0);
      check("rst_op",  32'(op_a),  0);
      check("rst_ill", 32'(ill_a), 0);
      rst_n = 1'b1;
      step();
      check("idle_rdy", 32'({rdy_a, rdy_b}), 32'b11);

      // ADD: 4 cycles
      issue(I_ADD);
      check("add_dec_rdy", 32'(rdy_a), 0);
      check("add_dec_pcw", 32'(pcw_a), 0);
      step();
      check("add_exec", 32'({op_a, src_a, r2l_a, pcw_a}), 32'({3'b000, 1'b0, 1'b0, 1'b0}));
      step();
      check("add_wb", 32'({rw_a, m2r_a, pcw_a, pcb_a}), 32'b1010);
      step();
      check("add_rdy4", 32'({rdy_a, rdy_b}), 32'b11);

      // LDUR on A (latency 3): 7 cycles
      issue(I_LDUR);
      step();
      check("ldur_exec", 32'({op_a, src_a, r2l_a, mr_a}), 32'({3'b000, 1'b1, 1'b0, 1'b0}));
      for (int i = 0; i < 3; i++) begin
         step();
         check("ldur_mem", 32'({mr_a, op_a, src_a, pcw_a, rw_a}), 32'({1'b1, 3'b000, 1'b1, 1'b0, 1'b0}));
      end
      step();
      check("ldur_wb", 32'({mr_a, rw_a, m2r_a, pcw_a, pcb_a, src_a}), 32'b011101);
      step();
      check("ldur_rdy7", 32'({rdy_a, rdy_b}), 32'b10);
      step();
      check("ldur_b_rdy8", 32'(rdy_b), 1);

      // STUR on A (latency 3): 6 cycles, pc_write in last MEM cycle
      issue(I_STUR);
      step();
      check("stur_exec", 32'({src_a, r2l_a}), 32'b11);
      step();
      check("stur_mem1", 32'({mw_a, pcw_a}), 32'b10);
      step();
      check("stur_mem2", 32'({mw_a, pcw_a}), 32'b10);
      step();
      check("stur_mem3", 32'({mw_a, pcw_a, pcb_a, rw_a}), 32'b1100);
      step();
      check("stur_rdy6", 32'({rdy_a, mw_a}), 32'b10);
      step();
      check("stur_b_rdy7", 32'(rdy_b), 1);

      // CBZ taken, then not taken; pc_branch follows zero within EXEC
      zero = 1'b1;
      issue(I_CBZ);
      step();
      check("cbz1_exec", 32'({op_a, r2l_a, src_a, pcw_a, pcb_a}), 32'({3'b100, 1'b1, 1'b0, 1'b1, 1'b1}));
      zero = 1'b0;
      #1;
      check("cbz1_comb", 32'(pcb_a), 0);
      step();
      check("cbz1_rdy3", 32'({rdy_a, pcw_a}), 32'b10);
      issue(I_CBZ);
      step();
      check("cbz0_exec", 32'({op_a, r2l_a, pcw_a, pcb_a}), 32'({3'b100, 1'b1, 1'b1, 1'b0}));
      step();

      // B and an illegal word
      issue(I_B);
      check("b_dec", 32'({pcw_a, pcb_a, rw_a, mr_a, mw_a, ill_a}), 32'b110000);
      step();
      check("b_rdy2", 32'({rdy_a, pcw_a}), 32'b10);
      issue(I_BAD);
      check("ill_dec", 32'({ill_a, pcw_a, pcb_a, rw_a, mr_a, mw_a}), 32'b110000);
      step();
      check("ill_pulse", 32'({ill_a, rdy_a}), 32'b01);

      // STUR on B (latency 4), reset pulsed in 2nd MEM cycle
      issue(I_STUR);
      step();
      step();
      check("sturb_mem1", 32'({mw_b, pcw_b}), 32'b10);
      step();
      check("sturb_mem2", 32'({mw_b, pcw_b}), 32'b10);
      #2;
      rst_n = 1'b0;
      #1;
      check("sturb_async", 32'({mw_b, pcw_b, mw_a}), 0);
      step();
      check("sturb_rst_pcw", 32'(pcw_b), 0);
      rst_n = 1'b1;
      step();
      check("sturb_rel", 32'({rdy_b, mw_b, pcw_b}), 32'b100);

      // Back-to-back ORR then SUB with valid held high
      cnt_en      = 1'b1;
      instr       = I_ORR;
      instr_valid = 1'b1;
      step();
      instr = I_SUB;
      check("orr_dec_rdy", 32'(rdy_a), 0);
      step();
      check("orr_exec", 32'(op_a), 32'(3'b011));
      step();
      check("orr_wb", 32'(pcw_a), 1);
      step();
      check("sub_idle_rdy", 32'(rdy_a), 1);
      step();
      check("sub_dec_rdy", 32'(rdy_a), 0);
      step();
      check("sub_exec", 32'(op_a), 32'(3'b001));
      instr_valid = 1'b0;
      step();
      check("sub_wb", 32'(pcw_a), 1);
      step();
      cnt_en = 1'b0;
      check("stream_pcw", n_pcw, 2);
      check("stream_rdy", 32'(rdy_a), 1);
      check("rw_mw_excl", n_excl, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
